button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Per-channel button event generator sitting directly downstream of the debouncer. It consumes clean, clock-synchronous button levels and turns each one into single-cycle event strobes: press, release, click (short press), long-press and auto-repeat, plus a held level. UI and control logic consume the strobes directly, with no further edge detection.

## Interface
- `CH`, default 2: number of independent button channels.
- `LONG_CYCLES`, default 50_000_000: clock cycles a press must persist before a long-press event fires; legal range ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period while held after a long press; 0 disables repeat.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn`, input, CH: debounced button levels, 1 = pressed; already synchronous to `clk`.
- `press`, output, CH: 1-cycle strobe on a press.
- `release_o`, output, CH: 1-cycle strobe on every release.
- `click`, output, CH: 1-cycle strobe on a release that occurs before the long-press threshold.
- `long_press`, output, CH: 1-cycle strobe when the long-press threshold is reached.
- `repeat_o`, output, CH: 1-cycle strobe at each auto-repeat tick.
- `held`, output, CH: level, high while the channel is in HELD.

## Operation
- Channels are fully independent: per channel, one FSM plus one counter `cnt`.
- `cnt` width is `$clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1)`. It is unsigned, never wraps, and is cleared on every state change.
- All outputs are registered. Strobes default to 0 every cycle unless set below.
- States: IDLE, PRESSED, HELD.
- **IDLE**
  - `btn`=1 → PRESSED, `press`<=1, `cnt`<=0.
  - Otherwise stay.
- **PRESSED**
  - `btn`=0 → IDLE, `release_o`<=1, `click`<=1.
  - Else if `cnt`==LONG_CYCLES-1 → HELD, `long_press`<=1, `cnt`<=0.
  - Else `cnt`<=`cnt`+1.
- **HELD**
  - `btn`=0 → IDLE, `release_o`<=1 (no `click`).
  - Else if REPEAT_CYCLES≠0 and `cnt`==REPEAT_CYCLES-1 → `repeat_o`<=1, `cnt`<=0.
  - Else if REPEAT_CYCLES≠0, `cnt`<=`cnt`+1.
  - If REPEAT_CYCLES=0, `cnt` holds at 0.
- `held` is registered; it is high exactly while state == HELD.
- Release takes priority over the threshold. If `btn`=0 on the edge where `cnt` hits the threshold, only the release/click is produced.
- A press lasting 1 cycle (`btn` high for a single edge) yields `press` followed next cycle by `release_o` + `click`.

## Timing
- Reset: while `rst_n`=0, every channel is in IDLE with `cnt`=0. `press`, `release_o`, `click`, `long_press`, `repeat_o` and `held` are all 0.
- Reset is asynchronous assert, synchronous to `clk` after deassert.
- Reset mid-operation: any in-flight press is discarded and no release strobe is emitted.
- If `btn`=1 at the first edge after deassert, `press` fires, i.e. it is treated as a new press.
- Let edge k be the first edge sampling `btn`=1 in IDLE. Then:
  - `press` is high in the cycle after edge k (1-cycle latency).
  - `long_press` is high after edge k+LONG_CYCLES, provided `btn`=1 on every edge k..k+LONG_CYCLES.
  - `held` rises in that same cycle.
  - `repeat_o` is high after edges k+LONG_CYCLES+n·REPEAT_CYCLES, n ≥ 1.
  - With REPEAT_CYCLES=1, `repeat_o` is high every cycle while held.
- Release: `release_o` (and `click` if applicable) is high in the cycle after the first edge sampling `btn`=0. `held` falls in that same cycle.
- Every strobe lasts exactly 1 cycle. Strobes never overlap on a channel, except `release_o` with `click`.
- Multiple channels may strobe in the same cycle.

## Test plan
Bench parameters: CH=2, LONG_CYCLES=8, REPEAT_CYCLES=4.
1. Reset, then `btn`=00 idle for 20 cycles → all outputs 0 throughout.
2. `btn[0]` high for 3 edges → `press[0]` 1 cycle after the first edge; `release_o[0]` and `click[0]` together 1 cycle after the first low edge; no `long_press`.
3. `btn[0]` high for 20 edges from edge k → `long_press[0]` + `held[0]` after edge k+8; `repeat_o[0]` after edges k+12 and k+16; `release_o[0]` without `click[0]` on release.
4. `btn[0]` drops on exactly edge k+8 → `release_o[0]` + `click[0]`, no `long_press[0]`.
5. `btn[0]` and `btn[1]` rise on the same edge, `btn[1]` released after 2 cycles → `press`=11 simultaneously; channel 0 proceeds to `long_press` unaffected.
6. `rst_n` pulsed low while channel 0 is in HELD with `btn[0]` still 1 → outputs clear immediately; `press[0]` after the first edge post-deassert; `long_press[0]` again 8 edges later.

Source files
------------

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
//
// Per-channel button event generator. Consumes debounced, clk-synchronous
// button levels and produces single-cycle strobes for press, release, click
// (release before the long-press threshold), long-press and auto-repeat,
// plus a registered "held" level.
//
// Parameters
//   CH            number of independent channels
//   LONG_CYCLES   cycles a press must persist before long_press (>= 2)
//   REPEAT_CYCLES auto-repeat period while held; 0 disables repeat
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn        [CH] debounced levels, 1 = pressed
//   press      [CH] strobe on press
//   release_o  [CH] strobe on every release
//   click      [CH] strobe on release before the long-press threshold
//   long_press [CH] strobe when the long-press threshold is reached
//   repeat_o   [CH] strobe at each auto-repeat tick
//   held       [CH] level, high while the channel is in HELD
// -----------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int CH            = 2,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] press,
  output logic [CH-1:0] release_o,
  output logic [CH-1:0] click,
  output logic [CH-1:0] long_press,
  output logic [CH-1:0] repeat_o,
  output logic [CH-1:0] held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // Terminal counts; the repeat one is unused when repeat is disabled.
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit            REPEAT_EN   = (REPEAT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          press_reg, press_next;
      logic          release_reg, release_next;
      logic          click_reg, click_next;
      logic          long_reg, long_next;
      logic          repeat_reg, repeat_next;
      logic          held_reg, held_next;

      always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        click_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        unique case (state_reg)
          IDLE: begin
            if (btn[gi]) begin
              state_next = PRESSED;
              press_next = 1'b1;
              cnt_next   = '0;
            end
          end
          PRESSED: begin
            // Release wins over the threshold on the same edge.
            if (!btn[gi]) begin
              state_next   = IDLE;
              release_next = 1'b1;
              click_next   = 1'b1;
              cnt_next     = '0;
            end else if (cnt_reg == LONG_LAST) begin
              state_next = HELD;
              long_next  = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          HELD: begin
            if (!btn[gi]) begin
              state_next   = IDLE;
              release_next = 1'b1;
              cnt_next     = '0;
            end else if (REPEAT_EN) begin
              if (cnt_reg == REPEAT_LAST) begin
                repeat_next = 1'b1;
                cnt_next    = '0;
              end else begin
                cnt_next = cnt_reg + CW'(1);
              end
            end else begin
              cnt_next = '0;
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        endcase

        // held is registered alongside the state, so it tracks HELD exactly.
        held_next = (state_next == HELD);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          click_reg   <= 1'b0;
          long_reg    <= 1'b0;
          repeat_reg  <= 1'b0;
          held_reg    <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          press_reg   <= press_next;
          release_reg <= release_next;
          click_reg   <= click_next;
          long_reg    <= long_next;
          repeat_reg  <= repeat_next;
          held_reg    <= held_next;
        end
      end

      assign press[gi]      = press_reg;
      assign release_o[gi]  = release_reg;
      assign click[gi]      = click_reg;
      assign long_press[gi] = long_reg;
      assign repeat_o[gi]   = repeat_reg;
      assign held[gi]       = held_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_event_ctrl
//
// Scoreboard bench for button_event_ctrl (CH=2, LONG_CYCLES=8, REPEAT_CYCLES=4).
// On every rising edge a run-length reference model (consecutive pressed edges
// per channel) pushes the expected output vector into a queue; on the
// following falling edge the entry is popped and compared with the DUT.
// Per-scenario event totals are also checked against fixed counts.
// -----------------------------------------------------------------------------
module tb_button_event_ctrl;

  localparam int CH = 2;
  localparam int L  = 8;
  localparam int R  = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn   = '0;
  logic [CH-1:0] press, release_o, click, long_press, repeat_o, held;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] click;
    logic [CH-1:0] lp;
    logic [CH-1:0] rep;
    logic [CH-1:0] held;
  } exp_t;

  exp_t exp_q[$];
  int   run_len [CH];

  // Running totals of DUT strobes, written only by the sampling process.
  int cnt_press [CH];
  int cnt_rel   [CH];
  int cnt_click [CH];
  int cnt_lp    [CH];
  int cnt_rep   [CH];

  button_event_ctrl #(
    .CH           (CH),
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .press     (press),
    .release_o (release_o),
    .click     (click),
    .long_press(long_press),
    .repeat_o  (repeat_o),
    .held      (held)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: run_len counts consecutive edges sampling btn=1.
  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) run_len[c] = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        int h;
        h = run_len[c];
        if (btn[c]) begin
          h = h + 1;
          e.press[c] = (h == 1);
          e.lp[c]    = (h == L + 1);
          e.held[c]  = (h >= L + 1);
          e.rep[c]   = (h > L + 1) && (((h - 1 - L) % R) == 0);
          run_len[c] = h;
        end else begin
          e.rel[c]   = (h > 0);
          e.click[c] = (h > 0) && (h <= L);
          run_len[c] = 0;
        end
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      check_val("press",      32'(press),      32'(e.press));
      check_val("release_o",  32'(release_o),  32'(e.rel));
      check_val("click",      32'(click),      32'(e.click));
      check_val("long_press", 32'(long_press), 32'(e.lp));
      check_val("repeat_o",   32'(repeat_o),   32'(e.rep));
      check_val("held",       32'(held),       32'(e.held));
      if (|{press, release_o, click, long_press, repeat_o})
        $display("[TB] t=%0t press=%b rel=%b click=%b long=%b rep=%b held=%b",
                 $time, press, release_o, click, long_press, repeat_o, held);
      for (int c = 0; c < CH; c++) begin
        cnt_press[c] += int'(press[c]);
        cnt_rel[c]   += int'(release_o[c]);
        cnt_click[c] += int'(click[c]);
        cnt_lp[c]    += int'(long_press[c]);
        cnt_rep[c]   += int'(repeat_o[c]);
      end
    end
  end

  // Apply a btn value right after a rising edge and keep it for n edges.
  task automatic hold_btn(input logic [CH-1:0] v, input int n);
    btn = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_press [CH];
  int b_rel   [CH];
  int b_click [CH];
  int b_lp    [CH];
  int b_rep   [CH];

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      b_press[c] = cnt_press[c];
      b_rel[c]   = cnt_rel[c];
      b_click[c] = cnt_click[c];
      b_lp[c]    = cnt_lp[c];
      b_rep[c]   = cnt_rep[c];
    end
  endtask

  task automatic check_counts(input string tag, input int c,
                              input int p, input int r, input int k,
                              input int l, input int rp);
    check_val({tag, "_press_cnt"},  32'(cnt_press[c] - b_press[c]), 32'(p));
    check_val({tag, "_rel_cnt"},    32'(cnt_rel[c]   - b_rel[c]),   32'(r));
    check_val({tag, "_click_cnt"},  32'(cnt_click[c] - b_click[c]), 32'(k));
    check_val({tag, "_long_cnt"},   32'(cnt_lp[c]    - b_lp[c]),    32'(l));
    check_val({tag, "_repeat_cnt"}, 32'(cnt_rep[c]   - b_rep[c]),   32'(rp));
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      run_len[c] = 0;
      cnt_press[c] = 0; cnt_rel[c] = 0; cnt_click[c] = 0; cnt_lp[c] = 0; cnt_rep[c] = 0;
    end

    // 1: reset, then idle
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 32'({press, release_o, click, long_press, repeat_o, held}), 32'd0);
    rst_n = 1'b1;
    snap();
    $display("[TB] scenario 1: idle 20 cycles");
    hold_btn(2'b00, 20);
    check_counts("idle", 0, 0, 0, 0, 0, 0);

    // 2: short click
    snap();
    $display("[TB] scenario 2: short press 3 edges");
    hold_btn(2'b01, 3);
    hold_btn(2'b00, 5);
    check_counts("click", 0, 1, 1, 1, 0, 0);

    // 3: long press with repeats
    snap();
    $display("[TB] scenario 3: hold 20 edges");
    hold_btn(2'b01, 20);
    hold_btn(2'b00, 5);
    check_counts("long", 0, 1, 1, 0, 1, 2);

    // 4: release exactly on the threshold edge
    snap();
    $display("[TB] scenario 4: release on threshold edge");
    hold_btn(2'b01, L);
    hold_btn(2'b00, 5);
    check_counts("thresh", 0, 1, 1, 1, 0, 0);

    // 5: both channels pressed together, ch1 short
    snap();
    $display("[TB] scenario 5: dual press");
    hold_btn(2'b11, 2);
    hold_btn(2'b01, 10);
    hold_btn(2'b00, 5);
    check_counts("dual0", 0, 1, 1, 0, 1, 0);
    check_counts("dual1", 1, 1, 1, 1, 0, 0);

    // 6: reset while held
    snap();
    $display("[TB] scenario 6: reset while held");
    hold_btn(2'b01, 12);
    check_val("pre_reset_held", 32'(held), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("reset_clear", 32'({press, release_o, click, long_press, repeat_o, held}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_btn(2'b01, 12);
    hold_btn(2'b00, 5);
    check_counts("rst", 0, 2, 1, 0, 2, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
